// File: rtl/score_event_arbiter.sv
// rtl/score_event_arbiter.sv - round-robin lane event arbiter feeding shared BCD score counters
module score_event_arbiter #(
    parameter int NUM_LANES = 4,
    parameter int PTS_W     = 3
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         clear,
    input  logic [NUM_LANES-1:0]         lane_hit,
    input  logic [NUM_LANES-1:0]         lane_miss,
    input  logic [NUM_LANES*PTS_W-1:0]   lane_pts,
    output logic [15:0]                  score,
    output logic [15:0]                  num_hits,
    output logic [15:0]                  num_misses,
    output logic [7:0]                   streak,
    output logic [7:0]                   best_streak,
    output logic                         busy,
    output logic                         drop_err
);

    localparam int PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    // Per-lane pending slots
    logic [NUM_LANES-1:0] slot_valid;
    logic [NUM_LANES-1:0] slot_hit;
    logic [PTS_W-1:0]     slot_pts [NUM_LANES];

    logic [PTR_W-1:0]     rr_ptr;

    // Commit stage register
    logic                 c_valid;
    logic                 c_hit;
    logic [PTS_W-1:0]     c_pts;

    logic                 grant_found;
    logic [PTR_W-1:0]     grant_idx;
    logic [PTR_W-1:0]     next_ptr;
    logic [15:0]          streak_wide;
    logic [7:0]           streak_inc;

    // 4-digit BCD add of a small value; any carry out of the top digit pins the result at 9999
    function automatic logic [15:0] bcd_add16(input logic [15:0] a, input logic [3:0] b);
        logic [15:0] r;
        logic [4:0]  d;
        logic [4:0]  s;
        logic [4:0]  c;
        r = 16'h0000;
        c = {1'b0, b};
        for (int i = 0; i < 4; i++) begin
            d = {1'b0, a[i*4 +: 4]} + c;
            if (d > 5'd9) begin
                s = d - 5'd10;
                r[i*4 +: 4] = s[3:0];
                c = 5'd1;
            end else begin
                r[i*4 +: 4] = d[3:0];
                c = 5'd0;
            end
        end
        if (c != 5'd0) begin
            r = 16'h9999;
        end
        return r;
    endfunction

    // Round-robin scan starting at rr_ptr, first valid slot wins
    always_comb begin
        int j;
        grant_found = 1'b0;
        grant_idx   = '0;
        j           = 0;
        for (int k = 0; k < NUM_LANES; k++) begin
            j = (int'(rr_ptr) + k) % NUM_LANES;
            if (!grant_found && slot_valid[j]) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'(j);
            end
        end
        if (grant_idx == PTR_W'(NUM_LANES - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = grant_idx + PTR_W'(1);
        end
    end

    // Two-digit streak increment, saturating at 99
    always_comb begin
        streak_wide = bcd_add16({8'h00, streak}, 4'd1);
        if (streak_wide[15:8] != 8'h00) begin
            streak_inc = 8'h99;
        end else begin
            streak_inc = streak_wide[7:0];
        end
    end

    assign busy = (|slot_valid) | c_valid;

    // Slots, arbitration stage, commit stage and counters
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            slot_valid  <= '0;
            slot_hit    <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                slot_pts[i] <= '0;
            end
            rr_ptr      <= '0;
            c_valid     <= 1'b0;
            c_hit       <= 1'b0;
            c_pts       <= '0;
            score       <= 16'h0000;
            num_hits    <= 16'h0000;
            num_misses  <= 16'h0000;
            streak      <= 8'h00;
            best_streak <= 8'h00;
            drop_err    <= 1'b0;
        end else if (clear) begin
            slot_valid  <= '0;
            slot_hit    <= '0;
            rr_ptr      <= '0;
            c_valid     <= 1'b0;
            c_hit       <= 1'b0;
            c_pts       <= '0;
            score       <= 16'h0000;
            num_hits    <= 16'h0000;
            num_misses  <= 16'h0000;
            streak      <= 8'h00;
            best_streak <= 8'h00;
            drop_err    <= 1'b0;
        end else begin
            if (c_valid) begin
                if (c_hit) begin
                    num_hits <= bcd_add16(num_hits, 4'd1);
                    score    <= bcd_add16(score, 4'(c_pts));
                    streak   <= streak_inc;
                    if (streak_inc > best_streak) begin
                        best_streak <= streak_inc;
                    end
                end else begin
                    num_misses <= bcd_add16(num_misses, 4'd1);
                    streak     <= 8'h00;
                end
            end

            c_valid <= grant_found;
            if (grant_found) begin
                c_hit  <= slot_hit[grant_idx];
                c_pts  <= slot_pts[grant_idx];
                rr_ptr <= next_ptr;
            end

            // A slot being granted this edge frees up in time to take a new pulse
            for (int i = 0; i < NUM_LANES; i++) begin
                if (lane_hit[i] || lane_miss[i]) begin
                    if (slot_valid[i] && !(grant_found && grant_idx == PTR_W'(i))) begin
                        drop_err <= 1'b1;
                    end else begin
                        slot_valid[i] <= 1'b1;
                        slot_hit[i]   <= lane_hit[i];
                        slot_pts[i]   <= lane_pts[i*PTS_W +: PTS_W];
                    end
                end else if (grant_found && grant_idx == PTR_W'(i)) begin
                    slot_valid[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_score_event_arbiter.sv
// tb/tb_score_event_arbiter.sv - self-checking bench for score_event_arbiter
module tb_score_event_arbiter;

    localparam int N = 4;
    localparam int P = 3;

    logic            clk;
    logic            n_rst;
    logic            clear;
    logic [N-1:0]    lane_hit;
    logic [N-1:0]    lane_miss;
    logic [N*P-1:0]  lane_pts;
    logic [15:0]     score;
    logic [15:0]     num_hits;
    logic [15:0]     num_misses;
    logic [7:0]      streak;
    logic [7:0]      best_streak;
    logic            busy;
    logic            drop_err;

    int checks;
    int errors;

    // Reference model state, plain integers
    int m_score, m_hits, m_misses, m_streak, m_best;
    bit m_drop;
    bit m_sv [N];
    bit m_sh [N];
    int m_sp [N];
    bit m_cv;
    bit m_ch;
    int m_cp;
    int m_ptr;

    score_event_arbiter #(.NUM_LANES(N), .PTS_W(P)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .clear       (clear),
        .lane_hit    (lane_hit),
        .lane_miss   (lane_miss),
        .lane_pts    (lane_pts),
        .score       (score),
        .num_hits    (num_hits),
        .num_misses  (num_misses),
        .streak      (streak),
        .best_streak (best_streak),
        .busy        (busy),
        .drop_err    (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_score = 0; m_hits = 0; m_misses = 0; m_streak = 0; m_best = 0;
        m_drop = 0; m_cv = 0; m_ch = 0; m_cp = 0; m_ptr = 0;
        for (int i = 0; i < N; i++) begin
            m_sv[i] = 0; m_sh[i] = 0; m_sp[i] = 0;
        end
    endtask

    task automatic model_edge(input logic [N-1:0] h, input logic [N-1:0] m,
                              input logic [N*P-1:0] p, input logic c);
        int g;
        if (c) begin
            model_reset();
            return;
        end
        if (m_cv) begin
            if (m_ch) begin
                m_hits   = imin(m_hits + 1, 9999);
                m_score  = imin(m_score + m_cp, 9999);
                m_streak = imin(m_streak + 1, 99);
                if (m_streak > m_best) m_best = m_streak;
            end else begin
                m_misses = imin(m_misses + 1, 9999);
                m_streak = 0;
            end
        end
        g = -1;
        for (int k = 0; k < N; k++) begin
            if (g < 0 && m_sv[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
        if (g >= 0) begin
            m_cv = 1; m_ch = m_sh[g]; m_cp = m_sp[g];
            m_sv[g] = 0;
            m_ptr = (g + 1) % N;
        end else begin
            m_cv = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (h[i] || m[i]) begin
                if (m_sv[i]) begin
                    m_drop = 1;
                end else begin
                    m_sv[i] = 1; m_sh[i] = h[i]; m_sp[i] = int'(p[i*P +: P]);
                end
            end
        end
    endtask

    task automatic check_model();
        bit mb;
        mb = m_cv;
        for (int i = 0; i < N; i++) mb = mb | m_sv[i];
        chk("score", score, to_bcd(m_score));
        chk("num_hits", num_hits, to_bcd(m_hits));
        chk("num_misses", num_misses, to_bcd(m_misses));
        chk("streak", {8'h00, streak}, to_bcd(m_streak));
        chk("best_streak", {8'h00, best_streak}, to_bcd(m_best));
        chk("busy", {15'd0, busy}, {15'd0, mb});
        chk("drop_err", {15'd0, drop_err}, {15'd0, m_drop});
    endtask

    // One clock: drive, clock edge, advance model, compare, return inputs to idle
    task automatic step(input logic [N-1:0] h, input logic [N-1:0] m,
                        input logic [N*P-1:0] p, input logic c);
        lane_hit = h; lane_miss = m; lane_pts = p; clear = c;
        @(posedge clk);
        model_edge(h, m, p, c);
        #1;
        check_model();
        lane_hit = '0; lane_miss = '0; lane_pts = '0; clear = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, '0, 1'b0);
    endtask

    initial begin
        logic [N-1:0]   rh;
        logic [N-1:0]   rm;
        logic [N*P-1:0] rp;
        checks = 0;
        errors = 0;
        n_rst = 1'b0; clear = 1'b0;
        lane_hit = '0; lane_miss = '0; lane_pts = '0;
        model_reset();
        #12;
        check_model();
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        // Lone hit, lane 0, 6 points
        step(4'b0001, 4'b0000, 12'd6, 1'b0);
        idle(1);
        chk("t1_score_early", score, 16'h0000);
        idle(1);
        chk("t1_score", score, 16'h0006);
        chk("t1_hits", num_hits, 16'h0001);
        chk("t1_streak", {8'h00, streak}, 16'h0001);
        idle(1);
        chk("t1_busy", {15'd0, busy}, 16'h0000);

        // Four lanes together, committed in lane order
        step('0, '0, '0, 1'b1);
        step(4'b1111, 4'b0000, {3'd3, 3'd6, 3'd4, 3'd3}, 1'b0);
        idle(5);
        chk("t2_score", score, 16'h0016);
        chk("t2_hits", num_hits, 16'h0004);
        chk("t2_streak", {8'h00, streak}, 16'h0004);

        // BCD carry and saturation
        step('0, '0, '0, 1'b1);
        for (int i = 0; i < 14; i++) step(4'b0001, 4'b0000, 12'd7, 1'b0);
        idle(3);
        chk("t3_score98", score, 16'h0098);
        step(4'b0001, 4'b0000, 12'd6, 1'b0);
        idle(3);
        chk("t3_score104", score, 16'h0104);
        for (int i = 0; i < 9999; i++) step(4'b0001, 4'b0000, 12'd7, 1'b0);
        idle(3);
        chk("t3_hits_sat", num_hits, 16'h9999);
        chk("t3_score_sat", score, 16'h9999);
        chk("t3_streak_sat", {8'h00, streak}, 16'h0099);

        // Overrun on a pending lane
        step('0, '0, '0, 1'b1);
        step(4'b1111, 4'b0000, 12'd0, 1'b0);
        step(4'b1000, 4'b0000, 12'd0, 1'b0);
        idle(6);
        chk("t4_drop", {15'd0, drop_err}, 16'h0001);
        chk("t4_hits", num_hits, 16'h0004);
        step('0, '0, '0, 1'b1);
        chk("t4_drop_clr", {15'd0, drop_err}, 16'h0000);
        chk("t4_hits_clr", num_hits, 16'h0000);

        // Streak broken by a miss; simultaneous hit+miss counts as hit
        for (int i = 0; i < 5; i++) step(4'b0001, 4'b0000, 12'd1, 1'b0);
        step(4'b0000, 4'b0100, 12'd0, 1'b0);
        idle(4);
        chk("t5_streak", {8'h00, streak}, 16'h0000);
        chk("t5_best", {8'h00, best_streak}, 16'h0005);
        chk("t5_misses", num_misses, 16'h0001);
        step(4'b0010, 4'b0010, 12'd2 << 3, 1'b0);
        idle(4);
        chk("t5_misses2", num_misses, 16'h0001);
        chk("t5_hits2", num_hits, 16'h0006);

        // Async reset with slots pending
        step(4'b0111, 4'b0000, 12'o0777, 1'b0);
        #2;
        n_rst = 1'b0;
        #1;
        model_reset();
        chk("t6_score", score, 16'h0000);
        chk("t6_hits", num_hits, 16'h0000);
        chk("t6_best", {8'h00, best_streak}, 16'h0000);
        chk("t6_busy", {15'd0, busy}, 16'h0000);
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        idle(4);
        chk("t6_no_stale", num_hits, 16'h0000);

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            rh = N'($urandom & $urandom);
            rm = N'($urandom & $urandom & $urandom);
            rp = (N*P)'($urandom);
            step(rh, rm, rp, ($urandom_range(0, 39) == 0));
        end
        idle(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
